ccip_rd_req_arbiter: RTL

Round-robin scheduler that shares the single CCI-P c0 memory-read request channel between NUM_REQ AFU-internal requesters. Examples are a number-fetch engine and a descriptor fetcher. The block sits between the requesters and the host_ccip sTx.c0/sRx.c0 fields. It tags each request's mdata with the requester index and routes each read response back to its owner. It enforces a per-requester outstanding-read limit, honours c0TxAlmFull, and supports a drain mode so the AFU FSM can quiesce reads before the next job.

---
 rtl/ccip_rd_req_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ccip_rd_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ccip_rd_req_arbiter
// Purpose  : Round-robin sharing of the CCI-P c0 read-request channel among
//            NUM_REQ requesters. Tags mdata with the requester index, routes
//            read responses back to their owner, limits outstanding reads
//            per requester, honours c0TxAlmFull and supports a drain mode.
// Revision : 1.0 - initial release
// ============================================================================
module ccip_rd_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 4,
  parameter int ADDR_W  = 42
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [511:0]              rsp_data_o,
  output logic                      c0_tx_valid_o,
  output logic [ADDR_W-1:0]         c0_tx_addr_o,
  output logic [15:0]               c0_tx_mdata_o,
  input  logic                      c0_tx_alm_full_i,
  input  logic                      c0_rx_rsp_valid_i,
  input  logic [15:0]               c0_rx_mdata_i,
  input  logic [511:0]              c0_rx_data_i,
  input  logic                      drain_i,
  output logic                      idle_o,
  output logic                      err_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int IDX_W = PTR_W + 1;
  localparam logic [3:0] C_MAX_OUT = 4'(MAX_OUT);

  // Registered state
  logic [3:0]          out_cnt_q [NUM_REQ];
  logic [3:0]          out_cnt_d [NUM_REQ];
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [7:0]          seq_q;
  logic                c0_tx_valid_q;
  logic [ADDR_W-1:0]   c0_tx_addr_q;
  logic [15:0]         c0_tx_mdata_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [511:0]        rsp_data_q;
  logic                idle_q;
  logic                err_q;

  // Combinational helpers
  logic                w_arb_en;
  logic [NUM_REQ-1:0]  w_elig;
  logic                w_gnt_valid;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic [IDX_W-1:0]    w_sum;
  logic [NUM_REQ-1:0]  w_gnt_onehot;
  logic [NUM_REQ-1:0]  w_rsp_hit;
  logic [NUM_REQ-1:0]  w_dec;
  logic                w_rsp_ok;
  logic                w_rsp_bad;
  logic                w_all_zero_d;
  logic [PTR_W-1:0]    w_rr_next;
  logic                w_unused_mdata;

  // Only the low mdata byte carries the requester index on the response path.
  assign w_unused_mdata = ^c0_rx_mdata_i[15:8];

  // Grants are suppressed globally during reset, drain or host almost-full.
  assign w_arb_en = !reset && !drain_i && !c0_tx_alm_full_i;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign w_elig[gi]       = req_valid_i[gi] && (out_cnt_q[gi] < C_MAX_OUT) && w_arb_en;
    assign w_gnt_onehot[gi] = w_gnt_valid && (w_gnt_idx == PTR_W'(gi));
  end

  // Round-robin search: first eligible index starting at rr_ptr, with wrap.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, rr_ptr_q} + IDX_W'(k);
      if (w_sum >= IDX_W'(NUM_REQ)) begin
        w_sum = w_sum - IDX_W'(NUM_REQ);
      end
      if (!w_gnt_valid && w_elig[w_sum[PTR_W-1:0]]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = w_sum[PTR_W-1:0];
      end
    end
  end

  assign req_ready_o = w_gnt_onehot;
  assign w_rr_next   = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // A response is accepted only for an in-range id whose counter is non-zero.
  always_comb begin
    w_rsp_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rsp_hit[i] = (c0_rx_mdata_i[7:0] == 8'(i)) && (out_cnt_q[i] != 4'd0);
    end
  end

  assign w_dec     = {NUM_REQ{c0_rx_rsp_valid_i}} & w_rsp_hit;
  assign w_rsp_ok  = |w_dec;
  assign w_rsp_bad = c0_rx_rsp_valid_i && !w_rsp_ok;

  // Outstanding counters: grant increments, routed response decrements.
  always_comb begin
    w_all_zero_d = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      if (w_gnt_onehot[i] && !w_dec[i]) begin
        out_cnt_d[i] = out_cnt_q[i] + 4'd1;
      end else if (w_dec[i] && !w_gnt_onehot[i]) begin
        out_cnt_d[i] = out_cnt_q[i] - 4'd1;
      end
      if (out_cnt_d[i] != 4'd0) begin
        w_all_zero_d = 1'b0;
      end
    end
  end

  // State, issue and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        out_cnt_q[i] <= '0;
      end
      rr_ptr_q      <= '0;
      seq_q         <= '0;
      c0_tx_valid_q <= 1'b0;
      c0_tx_addr_q  <= '0;
      c0_tx_mdata_q <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      idle_q        <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        out_cnt_q[i] <= out_cnt_d[i];
      end
      c0_tx_valid_q <= w_gnt_valid;
      if (w_gnt_valid) begin
        rr_ptr_q      <= w_rr_next;
        seq_q         <= seq_q + 8'd1;
        c0_tx_addr_q  <= req_addr_i[w_gnt_idx*ADDR_W +: ADDR_W];
        c0_tx_mdata_q <= {seq_q, 8'(w_gnt_idx)};
      end
      rsp_valid_q <= w_dec;
      if (w_rsp_ok) begin
        rsp_data_q <= c0_rx_data_i;
      end
      idle_q <= w_all_zero_d && !w_gnt_valid;
      if (w_rsp_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign c0_tx_valid_o = c0_tx_valid_q;
  assign c0_tx_addr_o  = c0_tx_addr_q;
  assign c0_tx_mdata_o = c0_tx_mdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign idle_o        = idle_q;
  assign err_o         = err_q;

endmodule
`default_nettype wire
